// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Segment encoding is active-low {g,f,e,d,c,b,a}; anodes are active-low one-hot.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [3:0] ANODE_OFF   = 4'hF;
  localparam logic [3:0] ANODE_RESET = 4'b1110;

  // Index is the hex nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Active-low anode pattern for the digit a scan state drives.
  function automatic logic [3:0] anode_for(scan_state_e s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/seven_seg_controller_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seven_seg_controller.sv
// Four-digit multiplexed seven-segment controller.
// SCAN_DIV clk cycles per digit slot; must be >= 8 and a multiple of 8.
// Optional feature macro SEG_DIM_EN adds a 3-bit brightness input that gates
// the anode for the late phases of each slot (8 phases of SCAN_DIV/8 cycles).
//
// state | meaning
// DIG0  | digit 0 slot; frame boundary is the tick leaving DIG3 into DIG0
// DIG1  | digit 1 slot
// DIG2  | digit 2 slot
// DIG3  | digit 3 slot; pending value may be promoted on its final tick
module seven_seg_controller
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  blank_mask,
`ifdef SEG_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count, count_next;
  logic          tick;
  scan_state_e   state, state_next;

  logic [15:0]   pend_data, act_data, act_data_next;
  logic [3:0]    pend_mask, act_mask, act_mask_next;
  logic          transfer;

  logic [3:0]    digit_val;
  logic          digit_blank;
  logic [6:0]    seg_dec;
  logic [3:0]    anode_d;
  logic [6:0]    seg_d;

  assign tick       = (count == CNT_MAX);
  assign count_next = tick ? '0 : count + CW'(1);
  assign transfer   = tick && (state == DIG3) && pending;

  // Outputs are registered from next-cycle values so anode and seg always
  // change together with the scan state and the active register.
  assign act_data_next = transfer ? pend_data : act_data;
  assign act_mask_next = transfer ? pend_mask : act_mask;

`ifdef SEG_DIM_EN
  localparam int PHASE_LEN = SCAN_DIV / 8;
  localparam int PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [PW-1:0] PHASE_MAX = PW'(PHASE_LEN - 1);

  logic [PW-1:0] sub_cnt, sub_next;
  logic [2:0]    phase, phase_next;
  logic          sub_last;

  assign sub_last   = (sub_cnt == PHASE_MAX);
  assign sub_next   = sub_last ? '0 : sub_cnt + PW'(1);
  assign phase_next = sub_last ? phase + 3'd1 : phase;

  // Phase tracker within the slot; wraps to phase 0 exactly on the slot tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_cnt <= '0;
      phase   <= 3'd0;
    end else begin
      sub_cnt <= sub_next;
      phase   <= phase_next;
    end
  end
`endif

  // Prescaler and scan state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      state <= DIG0;
    end else begin
      count <= count_next;
      state <= state_next;
    end
  end

  // Scan sequencing: advance one digit per tick.
  always_comb begin
    state_next = state;
    if (tick) begin
      unique case (state)
        DIG0: state_next = DIG1;
        DIG1: state_next = DIG2;
        DIG2: state_next = DIG3;
        DIG3: state_next = DIG0;
      endcase
    end
  end

  // Pending/active value registers; a load on the transfer tick is kept
  // pending while the older pending value goes live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_data  <= 16'h0000;
      pend_mask  <= 4'h0;
      act_data   <= 16'h0000;
      act_mask   <= 4'h0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= transfer;
      act_data   <= act_data_next;
      act_mask   <= act_mask_next;
      if (load) begin
        pend_data <= data;
        pend_mask <= blank_mask;
        pending   <= 1'b1;
      end else if (transfer) begin
        pending   <= 1'b0;
      end
    end
  end

  // Select the nibble and blank bit for the digit shown next cycle.
  always_comb begin
    digit_val   = act_data_next[3:0];
    digit_blank = act_mask_next[0];
    unique case (state_next)
      DIG0: begin digit_val = act_data_next[3:0];   digit_blank = act_mask_next[0]; end
      DIG1: begin digit_val = act_data_next[7:4];   digit_blank = act_mask_next[1]; end
      DIG2: begin digit_val = act_data_next[11:8];  digit_blank = act_mask_next[2]; end
      DIG3: begin digit_val = act_data_next[15:12]; digit_blank = act_mask_next[3]; end
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .hex (digit_val),
    .seg (seg_dec)
  );

  // Output decode: blanking and dimming only ever switch the anode off.
  always_comb begin
    anode_d = anode_for(state_next);
    seg_d   = seg_dec;
    if (digit_blank) begin
      anode_d = ANODE_OFF;
      seg_d   = SEG_BLANK;
    end
`ifdef SEG_DIM_EN
    if (phase_next > brightness) anode_d = ANODE_OFF;
`endif
  end

  // Registered display drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode <= ANODE_RESET;
      seg   <= HEX_SEG[0];
    end else begin
      anode <= anode_d;
      seg   <= seg_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_controller.sv
// Directed + randomized bench for seven_seg_controller with SCAN_DIV = 8.
module tb_seven_seg_controller;

  localparam int SCAN_DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  blank_mask = 4'h0;
  logic [2:0]  brightness = 3'd3;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  seven_seg_controller #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data       (data),
    .blank_mask (blank_mask),
`ifdef SEG_DIM_EN
    .brightness (brightness),
`endif
    .anode      (anode),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: t = clk edges since reset release.
  int          t;
  logic [15:0] m_pd, m_ad;
  logic [3:0]  m_pm, m_am;
  logic        m_pending, m_fd;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic void model_reset();
    t = 0;
    m_pd = 16'h0; m_ad = 16'h0;
    m_pm = 4'h0;  m_am = 4'h0;
    m_pending = 1'b0;
    m_fd = 1'b0;
  endfunction

  function automatic void model_edge(input logic l, input logic [15:0] d, input logic [3:0] m);
    int dig;
    bit x;
    dig = (t / SCAN_DIV) % 4;
    x = ((t % SCAN_DIV) == SCAN_DIV - 1) && (dig == 3) && m_pending;
    if (x) begin
      m_ad = m_pd;
      m_am = m_pm;
    end
    if (l) begin
      m_pd = d;
      m_pm = m;
      m_pending = 1'b1;
    end else if (x) begin
      m_pending = 1'b0;
    end
    m_fd = x;
    t++;
  endfunction

  task automatic check_outputs();
    int dig;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] es;
    dig = (t / SCAN_DIV) % 4;
    nib = m_ad[dig*4 +: 4];
    if (m_am[dig]) begin
      ea = 4'hF;
      es = 7'h7F;
    end else begin
      ea = ~(4'b0001 << dig);
      es = seg_tab[nib];
    end
`ifdef SEG_DIM_EN
    if (((t % SCAN_DIV) / (SCAN_DIV / 8)) > int'(brightness)) ea = 4'hF;
`endif
    check("anode", {12'h0, anode}, {12'h0, ea});
    check("seg", {9'h0, seg}, {9'h0, es});
    check("pending", {15'h0, pending}, {15'h0, m_pending});
    check("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
  endtask

  task automatic step(input logic l, input logic [15:0] d, input logic [3:0] m);
    load = l;
    data = d;
    blank_mask = m;
    @(posedge clk);
    model_edge(l, d, m);
    #1;
    load = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 4'h0);
  endtask

  // Step until the prescaler sits at the given digit/position (bounded).
  task automatic run_to(input int dig, input int pos);
    for (int i = 0; i < 64 && (t % 32) != dig * 8 + pos; i++) step(1'b0, 16'h0, 4'h0);
    check("run_to_reached", 16'(t % 32), 16'(dig * 8 + pos));
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Free scan with reset values.
    idle(40);

    // Load mid DIG1; transfer at the frame boundary.
    run_to(1, 3);
    step(1'b1, 16'h1234, 4'h0);
    check("pending_after_load", {15'h0, pending}, 16'h1);
    run_to(3, 7);
    step(1'b0, 16'h0, 4'h0);
    check("fd_on_transfer", {15'h0, frame_done}, 16'h1);
    check("dig0_shows_4", {9'h0, seg}, 16'h19);
    run_to(3, 0);
    check("dig3_shows_1", {9'h0, seg}, 16'h79);

    // Two loads in one frame: latest wins.
    run_to(0, 2);
    step(1'b1, 16'hAAAA, 4'h0);
    idle(5);
    step(1'b1, 16'h5555, 4'h0);
    idle(70);

    // Load coincident with transfer tick.
    run_to(1, 0);
    step(1'b1, 16'($urandom), 4'h0);
    run_to(3, 7);
    step(1'b1, 16'($urandom), 4'h0);
    check("pending_kept", {15'h0, pending}, 16'h1);
    idle(70);

    // Blanking digits 0 and 2.
    run_to(1, 0);
    step(1'b1, 16'hBEEF, 4'b0101);
    idle(70);

    // Random traffic.
    repeat (400) step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom));

    // Reset mid-slot while a value is pending and another load is presented.
    run_to(2, 3);
    step(1'b1, 16'($urandom), 4'h0);
    load = 1'b1;
    data = 16'($urandom);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    load = 1'b0;
    idle(40);
    repeat (200) step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
